// File: rtl/ins_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, format codes,
// the NOP word and the sequencer state encoding.
package ins_encoder_pkg;

   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_IMM    = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   // addi x0, x0, 0 -- substituted for any request that breaks a range rule
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FULL  = 2'd3
   } state_e;

endpackage

// File: rtl/ins_encoder_pack.sv
// Combinational RV32I word builder with immediate range checking;
// an illegal request yields the NOP word.
module ins_pack
   import ins_encoder_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   logic signed [31:0] simm;
   logic [31:0]        raw;

   assign simm = $signed(imm);

   always_comb begin
      raw     = NOP_WORD;
      illegal = 1'b0;
      case (fmt)
         FMT_R: raw = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            raw     = {imm[11:0], rs1, funct3, rd, opcode};
            illegal = (simm < -32'sd2048) || (simm > 32'sd2047);
         end
         FMT_S: begin
            raw     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            illegal = (simm < -32'sd2048) || (simm > 32'sd2047);
         end
         FMT_B: begin
            raw     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            illegal = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
         end
         FMT_U: begin
            raw     = {imm[31:12], rd, opcode};
            illegal = (imm[11:0] != 12'd0);
         end
         FMT_J: begin
            raw     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            illegal = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
         end
         default: illegal = 1'b1;
      endcase
      word = illegal ? NOP_WORD : raw;
   end

endmodule

// File: rtl/ins_encoder.sv
// Program-load sequencer: accepts encode requests, packs them into RV32I
// words and streams them to instruction memory through a one-deep output register.
//
// state | meaning
// IDLE  | no session open, waiting for start_i
// RUN   | accepting requests, writing words at an auto-incrementing pointer
// DRAIN | session finished, waiting for the last pending write to complete
// FULL  | DEPTH words accepted, refusing requests until start_i or finish_i
module ins_encoder
   import ins_encoder_pkg::*;
#(
   parameter int DEPTH = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic                    finish_i,
   input  logic [31:0]             base_addr_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [2:0]              fmt_i,
   input  logic [6:0]              opcode_i,
   input  logic [2:0]              funct3_i,
   input  logic [6:0]              funct7_i,
   input  logic [4:0]              rd_i,
   input  logic [4:0]              rs1_i,
   input  logic [4:0]              rs2_i,
   input  logic [31:0]             imm_i,
   output logic                    mem_wr_en_o,
   input  logic                    mem_wr_ready_i,
   output logic [31:0]             mem_wr_addr_o,
   output logic [31:0]             mem_wr_data_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    full_o,
   output logic                    err_o,
   output logic                    done_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

   state_e      state;
   logic [31:0] ptr;
   logic [31:0] word;
   logic        illegal;
   logic        accept;
   logic        restart;

   ins_pack u_pack (
      .fmt     (fmt_i),
      .opcode  (opcode_i),
      .funct3  (funct3_i),
      .funct7  (funct7_i),
      .rd      (rd_i),
      .rs1     (rs1_i),
      .rs2     (rs2_i),
      .imm     (imm_i),
      .word    (word),
      .illegal (illegal)
   );

   // A word leaving the register this cycle frees the slot for a new one.
   assign req_ready_o = (state == RUN) && (!mem_wr_en_o || mem_wr_ready_i);
   assign accept      = req_valid_i && req_ready_o;
   assign restart     = start_i && ((state == IDLE) || (state == FULL));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         ptr           <= 32'd0;
         mem_wr_en_o   <= 1'b0;
         mem_wr_addr_o <= 32'd0;
         mem_wr_data_o <= 32'd0;
         count_o       <= '0;
         full_o        <= 1'b0;
         err_o         <= 1'b0;
         done_o        <= 1'b0;
      end else begin
         done_o <= 1'b0;

         if (accept) begin
            mem_wr_en_o   <= 1'b1;
            mem_wr_addr_o <= ptr;
            mem_wr_data_o <= word;
            ptr           <= ptr + 32'd4;
            count_o       <= count_o + 1'b1;
            if (illegal)
               err_o <= 1'b1;
            if (count_o == LAST_CNT)
               full_o <= 1'b1;
         end else if (mem_wr_ready_i) begin
            mem_wr_en_o <= 1'b0;
         end

         case (state)
            RUN: begin
               if (finish_i)
                  state <= DRAIN;
               else if (accept && (count_o == LAST_CNT))
                  state <= FULL;
            end
            FULL: begin
               if (!start_i && finish_i)
                  state <= DRAIN;
            end
            DRAIN: begin
               if (!mem_wr_en_o || mem_wr_ready_i) begin
                  state  <= IDLE;
                  done_o <= 1'b1;
               end
            end
            default: ;
         endcase

         if (restart) begin
            state   <= RUN;
            ptr     <= base_addr_i;
            count_o <= '0;
            full_o  <= 1'b0;
            err_o   <= 1'b0;
         end
      end
   end

endmodule
